// File: rtl/alu8088_pkg.sv
// Shared encodings for the 8088 ALU slice: shift/rotate opcodes, sequencer
// states and operand MSB positions.
package alu8088_pkg;

  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_ROR = 3'd1;
  localparam logic [2:0] OP_RCL = 3'd2;
  localparam logic [2:0] OP_RCR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SAR = 3'd7;

  localparam int MSB_W = 15;
  localparam int MSB_B = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_rot_step.sv
// Combinational single-bit step of the shift/rotate group; byte mode works on
// bits [7:0] and passes the upper byte through untouched.
module shift_rot_step
  import alu8088_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] v,
  input  logic         c,
  input  logic [2:0]   op,
  input  logic         w,
  output logic [W-1:0] v_next,
  output logic         c_next,
  output logic         of_next
);

  localparam int MW = $clog2(W);

  logic [MW-1:0] m;
  logic [MW-1:0] m1;
  logic [W-1:0]  vn;

  always_comb begin
    m       = w ? MW'(MSB_W) : MW'(MSB_B);
    m1      = m - 1'b1;
    vn      = '0;
    c_next  = 1'b0;
    of_next = 1'b0;
    case (op)
      OP_ROL: begin
        c_next  = v[m];
        vn      = {v[W-2:0], v[m]};
        of_next = vn[m] ^ c_next;
      end
      OP_RCL: begin
        c_next  = v[m];
        vn      = {v[W-2:0], c};
        of_next = vn[m] ^ c_next;
      end
      OP_ROR: begin
        c_next  = v[0];
        vn      = v >> 1;
        vn[m]   = v[0];
        of_next = vn[m] ^ vn[m1];
      end
      OP_RCR: begin
        c_next  = v[0];
        vn      = v >> 1;
        vn[m]   = c;
        of_next = vn[m] ^ vn[m1];
      end
      OP_SHR: begin
        c_next  = v[0];
        vn      = v >> 1;
        vn[m]   = 1'b0;
        of_next = v[m];
      end
      OP_SAR: begin
        c_next  = v[0];
        vn      = v >> 1;
        vn[m]   = v[m];
        of_next = 1'b0;
      end
      // SHL and the reserved encoding 6 behave identically
      default: begin
        c_next  = v[m];
        vn      = v << 1;
        of_next = vn[m] ^ c_next;
      end
    endcase
    v_next = w ? vn : {v[W-1:8], vn[7:0]};
  end

endmodule

// File: rtl/shift_rot_seq.sv
// Multi-cycle 8088 shift/rotate sequencer: one bit position per clock,
// registered result/CF/OF presented with a one-cycle done pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for start; operands latched on acceptance
//   RUN     | one step per cycle, remaining count counts down to 1
//   DONE    | last step taken; outputs load and done fires next
module shift_rot_seq
  import alu8088_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic          w,
  input  logic [W-1:0]  data,
  input  logic [CW-1:0] count,
  input  logic          cf_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          cf,
  output logic          of,
  output logic          flags_upd
);

  state_t        state, nxt;
  logic [2:0]    op_r;
  logic          w_r;
  logic [W-1:0]  v_r;
  logic          c_r;
  logic          of_r;
  logic          nz_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  v_next;
  logic          c_next;
  logic          of_next;

  shift_rot_step #(.W(W)) u_step (
    .v       (v_r),
    .c       (c_r),
    .op      (op_r),
    .w       (w_r),
    .v_next  (v_next),
    .c_next  (c_next),
    .of_next (of_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = (count != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (cnt_r == CW'(1)) nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= '0;
      w_r       <= 1'b0;
      v_r       <= '0;
      c_r       <= 1'b0;
      of_r      <= 1'b0;
      nz_r      <= 1'b0;
      cnt_r     <= '0;
      done      <= 1'b0;
      result    <= '0;
      cf        <= 1'b0;
      of        <= 1'b0;
      flags_upd <= 1'b0;
    end else begin
      done      <= 1'b0;
      flags_upd <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          op_r  <= op;
          w_r   <= w;
          v_r   <= data;
          c_r   <= cf_in;
          of_r  <= 1'b0;
          nz_r  <= (count != '0);
          cnt_r <= count;
        end
        ST_RUN: begin
          v_r   <= v_next;
          c_r   <= c_next;
          of_r  <= of_next;
          cnt_r <= cnt_r - 1'b1;
        end
        ST_DONE: begin
          done      <= 1'b1;
          result    <= v_r;
          cf        <= c_r;
          of        <= of_r;
          flags_upd <= nz_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rot_seq.sv
// Scoreboard bench for shift_rot_seq: directed operations push hand-computed
// results; a negedge monitor pops and compares whenever done is seen.
module tb_shift_rot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        w;
  logic [15:0] data;
  logic [7:0]  count;
  logic        cf_in;
  logic        busy, done, cf, of, flags_upd;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    logic        cf;
    logic        of;
    logic        fu;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  shift_rot_seq #(.W(16), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .w         (w),
    .data      (data),
    .count     (count),
    .cf_in     (cf_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cf        (cf),
    .of        (of),
    .flags_upd (flags_upd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cf", 32'(cf), 32'(e.cf));
        chk("of", 32'(of), 32'(e.of));
        chk("flags_upd", 32'(flags_upd), 32'(e.fu));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic wd, input logic [15:0] d,
                       input logic [7:0] n, input logic ci, input logic [15:0] er,
                       input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    op = o; w = wd; data = d; count = n; cf_in = ci; start = 1'b1;
    e.res = er; e.cf = ec; e.of = eo; e.fu = (n != 0); e.cyc = cyc + int'(n) + 2;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic wd, input logic [15:0] d,
                        input logic [7:0] n, input logic ci, input logic [15:0] er,
                        input logic ec, input logic eo);
    issue(o, wd, d, n, ci, er, ec, eo);
    @(negedge clk);
    start = 1'b0;
    data  = 16'hDEAD;
    op    = 3'd4;
    wait_drain();
  endtask

  initial begin
    int busy_n;
    rst = 1'b1; start = 1'b0; op = '0; w = 1'b1; data = '0; count = '0; cf_in = 1'b0;
    #7;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cf", 32'(cf), 32'd0);
    chk("rst_of", 32'(of), 32'd0);
    chk("rst_flags_upd", 32'(flags_upd), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // op, w, data, count, cf_in -> result, cf, of
    run_op(3'd1, 1'b1, 16'h8001, 8'd1,   1'b0, 16'hC000, 1'b1, 1'b0); // ROR word
    run_op(3'd2, 1'b0, 16'hAB81, 8'd3,   1'b1, 16'hAB0E, 1'b0, 1'b0); // RCL byte
    run_op(3'd7, 1'b1, 16'h8000, 8'd17,  1'b0, 16'hFFFF, 1'b1, 1'b0); // SAR word, count>W
    run_op(3'd4, 1'b1, 16'h1234, 8'd0,   1'b1, 16'h1234, 1'b1, 1'b0); // count=0
    run_op(3'd5, 1'b1, 16'h8001, 8'd1,   1'b0, 16'h4000, 1'b1, 1'b1); // SHR word
    run_op(3'd3, 1'b0, 16'h1201, 8'd2,   1'b0, 16'h1280, 1'b0, 1'b1); // RCR byte
    run_op(3'd6, 1'b1, 16'h4000, 8'd1,   1'b0, 16'h8000, 1'b0, 1'b1); // reserved = SHL
    run_op(3'd0, 1'b0, 16'hFF80, 8'd9,   1'b0, 16'hFF01, 1'b1, 1'b1); // ROL byte, count>8
    run_op(3'd4, 1'b1, 16'hFFFF, 8'd255, 1'b1, 16'h0000, 1'b0, 1'b0); // max count

    // start held through RUN and DONE must be ignored
    issue(3'd0, 1'b1, 16'h0001, 8'd5, 1'b0, 16'h0020, 1'b0, 1'b0);
    busy_n = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      start = (i < 6);
      data  = 16'h5555;
      op    = 3'd1;
      count = 8'd3;
    end
    chk("busy_cycles", 32'(busy_n), 32'd5);
    wait_drain();
    repeat (10) @(negedge clk);
    run_op(3'd5, 1'b0, 16'h0003, 8'd1, 1'b0, 16'h0001, 1'b1, 1'b0); // back-to-back

    // reset mid-run abandons the operation
    @(negedge clk);
    op = 3'd0; w = 1'b1; data = 16'h00F0; count = 8'd200; cf_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    run_op(3'd0, 1'b1, 16'h0001, 8'd1, 1'b0, 16'h0002, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_rot_seq.md
Name: shift_rot_seq

Overview:
- Multi-cycle sequencer for the 8088 shift/rotate group: ROL, ROR, RCL, RCR, SHL/SAL, SHR and SAR, with byte or word width and a count of 0..255, as the 8088 takes it from CL.
- Iterates one bit position per clock, the way the 8088 microcode does.
- Produces the final result, CF and OF for the ALU flag stage.
- Sits between the ALU decode logic and the flag register. The single-step rotate datapath is a sub-module of this block.

Parameters:
- W, 16, datapath width in bits. Byte mode always uses bits [7:0].
- CW, 8, width of the count input.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  3  0=ROL 1=ROR 2=RCL 3=RCR 4=SHL 5=SHR 6=(reserved, treated as SHL) 7=SAR
- w  in  1  1=word (16-bit), 0=byte (8-bit)
- data  in  W  operand
- count  in  CW  shift count, unmasked (8088 semantics)
- cf_in  in  1  current carry flag
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- result  out  W  final value; valid while done=1 and held until the next accepted start
- cf  out  1  carry-flag result
- of  out  1  overflow-flag result
- flags_upd  out  1  equals done & (count != 0); flags stay unchanged when count=0

Behaviour:
- Reset (async, any state): state goes to IDLE. busy, done, result, cf, of and flags_upd all go to 0. Any operation in progress is abandoned with no done pulse.
- States:
  - IDLE: start=1 latches op, w, data, count and cf_in. Goes to RUN if count!=0, else DONE.
  - RUN: applies one 1-bit step per cycle and decrements the remaining count. Goes to DONE on the cycle that processes the last step.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge k gives done high after edge k+N+1 for count N (N=0 gives k+1). Back-to-back: a new start is accepted in the cycle after done (IDLE).
- start while busy or in DONE is ignored. No queueing.
- Per step, let m be the MSB index (15 for word, 7 for byte) and v the value bits [m:0]:
  - ROL: v={v[m-1:0],v[m]}, c=v[m]
  - ROR: v={v[0],v[m:1]}, c=v[0]
  - RCL: {c,v}={v,c}
  - RCR: {v,c}={c,v}
  - SHL: c=v[m], v<<1
  - SHR: c=v[0], v>>1
  - SAR: c=v[0], v>>1 with v[m] kept
- Byte mode: result[15:8] = data[15:8] unchanged.
- cf: the carry after the last step.
- of, computed on the last step:
  - left ops: of = new v[m] ^ c
  - ROR/RCR: of = new v[m] ^ new v[m-1]
  - SHR: of = v[m] before the last step
  - SAR: of = 0
- count=0: result=data; cf=cf_in and of=0 are driven, but flags_upd=0.
- Large counts (up to 255) iterate fully: no wrap or masking, and latency grows linearly.
- Inputs are ignored after latch; changing data or op during RUN has no effect.

Decomposition:
- Shared package (alu8088_pkg):
  - op encodings as localparams: OP_ROL, OP_ROR, OP_RCL, OP_RCR, OP_SHL, OP_SHR, OP_SAR
  - state encodings: ST_IDLE, ST_RUN, ST_DONE
  - MSB index constants: MSB_W=15, MSB_B=7
- One sub-module, shift_rot_step: combinational single-bit step taking (v, c, op, w) and returning (v_next, c_next, of_next). It is instantiated once. The FSM, count register and operand register stay in shift_rot_seq.

Test Plan:
- ROR word, data=16'h8001, count=1, cf_in=0 -> done at cycle 2: result=16'hC000, cf=1, of=0, flags_upd=1.
- RCL byte, data=16'hAB81, count=3, cf_in=1 -> done at cycle 4: result=16'hAB0E, cf=0, flags_upd=1. Upper byte unchanged.
- SAR word, data=16'h8000, count=17 -> done at cycle 18: result=16'hFFFF, cf=1, of=0.
- SHL word, data=16'h1234, count=0, cf_in=1 -> done at cycle 1: result=16'h1234, cf=1, flags_upd=0.
- start pulsed during RUN of a count=5 ROL -> ignored: one done only, busy stays high 5 cycles. Then a back-to-back start in IDLE is accepted.
- rst asserted mid-RUN (count=200) -> busy=0 and done=0 immediately, no done pulse ever. A subsequent ROL data=16'h0001 count=1 gives result=16'h0002.
